// File: rtl/spi_uc_arbiter_if.sv
// Bus between the SPI arbiter and its environment: requester handshake plus the
// SPI_MASTER_UC control/data lines. "master" is the arbiter view, "slave" the environment.
interface spi_uc_arbiter_if #(parameter int NREQ = 2);
   logic [NREQ-1:0]    REQ;
   logic [16*NREQ-1:0] REQ_DATA;
   logic [NREQ-1:0]    ACK;
   logic [NREQ-1:0]    ERR;
   logic [15:0]        RESP_DATA;
   logic               BUSY;
   logic               SPI_ENA;
   logic [15:0]        SPI_DATA_MOSI;
   logic               SPI_FIN;
   logic [15:0]        SPI_DATA_MISO;

   modport master (
      input  REQ, REQ_DATA, SPI_FIN, SPI_DATA_MISO,
      output ACK, ERR, RESP_DATA, BUSY, SPI_ENA, SPI_DATA_MOSI
   );

   modport slave (
      output REQ, REQ_DATA, SPI_FIN, SPI_DATA_MISO,
      input  ACK, ERR, RESP_DATA, BUSY, SPI_ENA, SPI_DATA_MOSI
   );
endinterface

// File: rtl/spi_uc_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one SPI_MASTER_UC between NREQ requesters,
// with MOSI setup before chip-select, a minimum CS-high gap and a transfer timeout.
//
// state | meaning
// IDLE  | waiting for any REQ; grant, latch owner and MOSI word
// LOAD  | ENA low, MOSI stable for SETUP_CYCLES
// XFER  | ENA high, wait for FIN rising edge or timeout
// DONE  | capture MISO, pulse ACK to owner
// GAP   | ENA low for at least GAP_CYCLES and until FIN reads low
module spi_uc_arbiter #(
   parameter int NREQ           = 2,
   parameter int SETUP_CYCLES   = 8,
   parameter int GAP_CYCLES     = 32,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   spi_uc_arbiter_if.master  bus
);

   localparam int MAX_SG  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
   localparam int CNT_MAX = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_XFER,
      ST_DONE,
      ST_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   last_q, last_d;
   logic            fin_q, fin_d;
   logic            ena_q, ena_d;
   logic [15:0]     mosi_q, mosi_d;
   logic [15:0]     resp_q, resp_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] err_q, err_d;

   logic [15:0]     req_word [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_word
      assign req_word[g] = bus.REQ_DATA[16*g +: 16];
   end

   logic [OW-1:0]     ptr;
   logic [OW-1:0]     pick;
   logic [OW-1:0]     grant;
   logic [OW:0]       grant_sum;
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              req_any;

   // Rotate REQ so the requester after last owner sits at bit 0, then take the lowest set bit.
   always_comb begin
      ptr       = (last_q == OW'(NREQ - 1)) ? '0 : last_q + OW'(1);
      req_dbl   = {bus.REQ, bus.REQ};
      req_rot   = NREQ'(req_dbl >> ptr);
      pick      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) pick = OW'(k);
      end
      grant_sum = {1'b0, ptr} + {1'b0, pick};
      if (grant_sum >= (OW+1)'(NREQ)) grant_sum = grant_sum - (OW+1)'(NREQ);
      grant     = grant_sum[OW-1:0];
      req_any   = |bus.REQ;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      fin_d   = bus.SPI_FIN;
      ena_d   = ena_q;
      mosi_d  = mosi_q;
      resp_d  = resp_q;
      ack_d   = '0;
      err_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               owner_d = grant;
               mosi_d  = req_word[grant];
               cnt_d   = CW'(SETUP_CYCLES - 1);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (cnt_q == '0) begin
               ena_d   = 1'b1;
               cnt_d   = CW'(TIMEOUT_CYCLES - 1);
               state_d = ST_XFER;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_XFER: begin
            if (bus.SPI_FIN && !fin_q) begin
               state_d = ST_DONE;
            end else if (cnt_q == '0) begin
               // A timed-out owner still counts as served so it cannot starve the others.
               err_d[owner_q] = 1'b1;
               ena_d          = 1'b0;
               last_d         = owner_q;
               cnt_d          = CW'(GAP_CYCLES - 1);
               state_d        = ST_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            resp_d         = bus.SPI_DATA_MISO;
            ack_d[owner_q] = 1'b1;
            ena_d          = 1'b0;
            last_d         = owner_q;
            cnt_d          = CW'(GAP_CYCLES - 1);
            state_d        = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (!bus.SPI_FIN) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
         last_q  <= OW'(NREQ - 1);
         fin_q   <= 1'b0;
         ena_q   <= 1'b0;
         mosi_q  <= '0;
         resp_q  <= '0;
         ack_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         fin_q   <= fin_d;
         ena_q   <= ena_d;
         mosi_q  <= mosi_d;
         resp_q  <= resp_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign bus.ACK           = ack_q;
   assign bus.ERR           = err_q;
   assign bus.RESP_DATA     = resp_q;
   assign bus.BUSY          = (state_q != ST_IDLE);
   assign bus.SPI_ENA       = ena_q;
   assign bus.SPI_DATA_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_uc_arbiter.sv
// Bench for spi_uc_arbiter: behavioural SPI master stand-in plus a round-robin reference model.
`timescale 1ns/1ps
module tb_spi_uc_arbiter;
   localparam int NREQ  = 2;
   localparam int SETUP = 8;
   localparam int GAP   = 32;
   localparam int TMO   = 1023;

   logic clk = 1'b0;
   logic rst = 1'b1;
   initial forever #5 clk = ~clk;

   spi_uc_arbiter_if #(.NREQ(NREQ)) bus();

   spi_uc_arbiter #(
      .NREQ(NREQ), .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .SYS_CLK(clk),
      .RST    (rst),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   initial forever begin @(posedge clk); cyc++; end

   // SPI master stand-in configuration and per-frame record
   int          fin_delay  = 136;
   bit          fin_stuck  = 1'b0;
   bit          miso_fixed = 1'b0;
   logic [15:0] miso_fix   = 16'h0000;
   int          hold_max   = 0;
   int          frames     = 0;
   logic [15:0] frame_mosi = 16'h0000;
   logic [15:0] frame_miso = 16'h0000;
   int          frame_hold = 0;
   bit          mosi_changed = 1'b0;
   int          ena_cyc = 0;
   int          low_cnt = 0;

   // reference model state
   int          exp_last  = NREQ - 1;
   logic [15:0] last_resp = 16'h0000;

   typedef struct {
      int              t;
      logic [NREQ-1:0] ack;
      logic [NREQ-1:0] err;
      logic [15:0]     resp;
   } ev_t;
   ev_t ev_q[$];

   int          t_grant = 0, t_idle = 0, t_ena_rise = 0, t_ena_fall = 0;
   logic [15:0] mosi_rise = 16'h0000;
   bit          busy_p = 1'b0, ena_p = 1'b0;
   int          viol = 0;

   // Stand-in master: latches MOSI while ENA is high, raises FIN after fin_delay cycles,
   // keeps FIN high until ENA drops and then for frame_hold more cycles.
   initial begin
      bus.SPI_FIN       = 1'b0;
      bus.SPI_DATA_MISO = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            ena_cyc = 0; low_cnt = 0; bus.SPI_FIN = 1'b0;
         end else if (!bus.SPI_ENA) begin
            ena_cyc = 0;
            if (low_cnt > 0) low_cnt--;
            else bus.SPI_FIN = 1'b0;
         end else begin
            if (ena_cyc == 0) begin
               frames++; frame_mosi = bus.SPI_DATA_MOSI; mosi_changed = 1'b0;
            end else if (bus.SPI_DATA_MOSI !== frame_mosi) begin
               mosi_changed = 1'b1;
            end
            ena_cyc++;
            if (!fin_stuck && ena_cyc == fin_delay) begin
               frame_miso = miso_fixed ? miso_fix : 16'($urandom);
               frame_hold = $urandom_range(hold_max, 0);
               low_cnt    = frame_hold;
               bus.SPI_DATA_MISO = frame_miso;
               bus.SPI_FIN       = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.BUSY && !busy_p) t_grant = cyc;
      if (!bus.BUSY && busy_p) t_idle = cyc;
      if (bus.SPI_ENA && !ena_p) begin t_ena_rise = cyc; mosi_rise = bus.SPI_DATA_MOSI; end
      if (!bus.SPI_ENA && ena_p) t_ena_fall = cyc;
      if ((bus.ACK | bus.ERR) != '0) begin
         if (!$onehot({bus.ACK, bus.ERR})) viol++;
         ev_q.push_back('{cyc, bus.ACK, bus.ERR, bus.RESP_DATA});
      end
      busy_p = bus.BUSY;
      ena_p  = bus.SPI_ENA;
   end

   function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic wait_ev(input int budget, output bit ok);
      int i = 0;
      while (ev_q.size() == 0 && i < budget) begin @(negedge clk); #1; i++; end
      ok = (ev_q.size() != 0);
   endtask

   task automatic wait_busy(input bit lvl, input int budget, output bit ok);
      int i = 0;
      while (bus.BUSY !== lvl && i < budget) begin @(negedge clk); #1; i++; end
      ok = (bus.BUSY === lvl);
   endtask

   task automatic wait_frame(input int n, input int budget, output bit ok);
      int i = 0;
      while (frames < n && i < budget) begin @(negedge clk); #1; i++; end
      ok = (frames >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.REQ = '0; bus.REQ_DATA = '0;
      repeat (3) @(negedge clk);
      total++; if (bus.SPI_ENA !== 1'b0) begin bad++; $display("FAIL reset_ena: got %b want 0", bus.SPI_ENA); end
      total++; if (bus.SPI_DATA_MOSI !== 16'h0) begin bad++; $display("FAIL reset_mosi: got %h want 0000", bus.SPI_DATA_MOSI); end
      total++; if (bus.RESP_DATA !== 16'h0) begin bad++; $display("FAIL reset_resp: got %h want 0000", bus.RESP_DATA); end
      total++; if (bus.ACK !== '0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.ACK); end
      total++; if (bus.ERR !== '0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
      #1 rst = 1'b0;
      exp_last = NREQ - 1; last_resp = 16'h0;
      @(negedge clk); #1;
   endtask

   task automatic test_single();
      bit ok; ev_t e; int f0; int own;
      fin_stuck = 1'b0; fin_delay = 136; miso_fixed = 1'b1; miso_fix = 16'h1234; hold_max = 0;
      ev_q.delete(); f0 = frames;
      bus.REQ_DATA = {16'($urandom), 16'hA5C3};
      bus.REQ = 2'b01;
      own = rr_pick(exp_last, 2'b01);
      wait_busy(1'b1, 50, ok); bus.REQ = '0;
      wait_ev(3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no ACK want ACK within 3000 cycles"); end
      if (ok) begin
         e = ev_q.pop_front();
         total++; if (e.ack !== 2'(1 << own)) begin bad++; $display("FAIL single_ack: got %b want %b", e.ack, 2'(1 << own)); end
         total++; if (e.err !== '0) begin bad++; $display("FAIL single_err: got %b want 0", e.err); end
         total++; if (e.resp !== 16'h1234) begin bad++; $display("FAIL single_resp: got %h want 1234", e.resp); end
         total++; if (mosi_rise !== 16'hA5C3 || mosi_changed) begin bad++; $display("FAIL single_mosi: got %h (changed=%0b) want a5c3", mosi_rise, mosi_changed); end
         total++; if (t_ena_rise - t_grant != SETUP) begin bad++; $display("FAIL single_setup: got %0d want %0d", t_ena_rise - t_grant, SETUP); end
         total++; if (e.t - t_ena_rise != fin_delay + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d", e.t - t_ena_rise, fin_delay + 1); end
         total++; if (t_ena_fall != e.t) begin bad++; $display("FAIL single_ena_fall: got %0d want %0d", t_ena_fall, e.t); end
         exp_last = own; last_resp = 16'h1234;
         wait_busy(1'b0, 200, ok);
         total++; if (!ok || t_idle - e.t != GAP) begin bad++; $display("FAIL single_gap: got %0d want %0d", t_idle - e.t, GAP); end
      end
      repeat (60) @(negedge clk);
      total++; if (frames - f0 != 1 || bus.SPI_ENA !== 1'b0) begin bad++; $display("FAIL single_frames: got %0d ena=%b want 1 ena=0", frames - f0, bus.SPI_ENA); end
      total++; if (ev_q.size() != 0) begin bad++; $display("FAIL single_extra_pulse: got %0d want 0", ev_q.size()); end
   endtask

   task automatic test_contention();
      bit ok; ev_t e; int f0; int own; int prev_t = 0; int prev_hold = 0; int exp_gap;
      logic [31:0] data; logic [15:0] exp_word; logic [NREQ-1:0] prev_ack = '0;
      fin_stuck = 1'b0; miso_fixed = 1'b0; hold_max = 40;
      ev_q.delete(); f0 = frames;
      data = {16'h2222, 16'h1111};
      bus.REQ_DATA = data; bus.REQ = 2'b11;
      for (int n = 0; n < 8; n++) begin
         fin_delay = $urandom_range(150, 120);
         own = rr_pick(exp_last, bus.REQ);
         exp_word = data[own*16 +: 16];
         wait_frame(f0 + n + 1, 500, ok);
         bus.REQ_DATA = {16'($urandom), 16'($urandom)};
         wait_ev(3000, ok);
         total++; if (!ok) begin bad++; $display("FAIL cont_timeout: frame %0d got no ACK want ACK", n); end
         if (!ok) break;
         e = ev_q.pop_front();
         total++; if (e.ack !== 2'(1 << own) || e.err !== '0) begin bad++; $display("FAIL cont_ack: frame %0d got ack=%b err=%b want ack=%b err=00", n, e.ack, e.err, 2'(1 << own)); end
         total++; if (e.ack === prev_ack) begin bad++; $display("FAIL cont_repeat_grant: frame %0d got %b twice want alternation", n, e.ack); end
         total++; if (mosi_rise !== exp_word || mosi_changed) begin bad++; $display("FAIL cont_mosi: frame %0d got %h (changed=%0b) want %h", n, mosi_rise, mosi_changed, exp_word); end
         total++; if (e.resp !== frame_miso) begin bad++; $display("FAIL cont_resp: frame %0d got %h want %h", n, e.resp, frame_miso); end
         exp_gap = (((prev_hold + 1) > GAP) ? prev_hold + 1 : GAP) + 1 + SETUP;
         if (n > 0) begin
            total++; if (t_ena_rise - prev_t != exp_gap) begin bad++; $display("FAIL cont_cs_gap: frame %0d got %0d want %0d", n, t_ena_rise - prev_t, exp_gap); end
         end
         prev_t = e.t; prev_hold = frame_hold; prev_ack = e.ack;
         exp_last = own; last_resp = frame_miso;
         data = (n < 3) ? {16'h2222, 16'h1111} : {16'($urandom), 16'($urandom)};
         bus.REQ_DATA = data;
      end
      bus.REQ = '0;
      wait_busy(1'b0, 300, ok);
      repeat (20) @(negedge clk);
      total++; if (!ok || ev_q.size() != 0) begin bad++; $display("FAIL cont_end: got busy=%b extra=%0d want busy=0 extra=0", bus.BUSY, ev_q.size()); end
   endtask

   task automatic test_timeout();
      bit ok; ev_t e; int own;
      fin_stuck = 1'b1; hold_max = 0; ev_q.delete();
      bus.REQ_DATA = {16'($urandom), 16'($urandom)};
      bus.REQ = 2'b10;
      own = rr_pick(exp_last, 2'b10);
      wait_busy(1'b1, 50, ok); bus.REQ = '0;
      wait_ev(TMO + 300, ok);
      total++; if (!ok) begin bad++; $display("FAIL tmo_wait: got no ERR want ERR within %0d cycles", TMO + 300); end
      if (ok) begin
         e = ev_q.pop_front();
         total++; if (e.err !== 2'(1 << own) || e.ack !== '0) begin bad++; $display("FAIL tmo_err: got err=%b ack=%b want err=%b ack=00", e.err, e.ack, 2'(1 << own)); end
         total++; if (e.resp !== last_resp) begin bad++; $display("FAIL tmo_resp: got %h want %h", e.resp, last_resp); end
         total++; if (e.t - t_ena_rise != TMO) begin bad++; $display("FAIL tmo_cycles: got %0d want %0d", e.t - t_ena_rise, TMO); end
         total++; if (t_ena_fall != e.t) begin bad++; $display("FAIL tmo_ena_fall: got %0d want %0d", t_ena_fall, e.t); end
         exp_last = own;
         wait_busy(1'b0, 200, ok);
         total++; if (!ok || t_idle - e.t != GAP) begin bad++; $display("FAIL tmo_gap: got %0d want %0d", t_idle - e.t, GAP); end
      end
      // stuck transfer on a contended bus: next owner must still rotate
      bus.REQ = 2'b11;
      own = rr_pick(exp_last, 2'b11);
      wait_busy(1'b1, 50, ok); bus.REQ = '0;
      wait_ev(TMO + 300, ok);
      total++; if (!ok) begin bad++; $display("FAIL tmo2_wait: got no ERR want ERR"); end
      if (ok) begin
         e = ev_q.pop_front();
         total++; if (e.err !== 2'(1 << own)) begin bad++; $display("FAIL tmo2_err: got %b want %b", e.err, 2'(1 << own)); end
         exp_last = own;
      end
      wait_busy(1'b0, 200, ok);
      fin_stuck = 1'b0; fin_delay = 128;
      bus.REQ = 2'b11;
      own = rr_pick(exp_last, 2'b11);
      wait_busy(1'b1, 50, ok); bus.REQ = '0;
      wait_ev(3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL tmo_recover_wait: got no ACK want ACK"); end
      if (ok) begin
         e = ev_q.pop_front();
         total++; if (e.ack !== 2'(1 << own) || e.resp !== frame_miso) begin bad++; $display("FAIL tmo_recover: got ack=%b resp=%h want ack=%b resp=%h", e.ack, e.resp, 2'(1 << own), frame_miso); end
         exp_last = own; last_resp = frame_miso;
      end
      wait_busy(1'b0, 200, ok);
   endtask

   task automatic test_req_drop();
      bit ok; ev_t e; int f0; int own;
      fin_stuck = 1'b0; fin_delay = 130; hold_max = 0; ev_q.delete(); f0 = frames;
      bus.REQ_DATA = {16'($urandom), 16'($urandom)};
      bus.REQ = 2'b01;
      own = rr_pick(exp_last, 2'b01);
      wait_frame(f0 + 1, 100, ok);
      repeat (10) @(negedge clk);
      bus.REQ = '0;
      // short request from the other side while busy: never reaches IDLE, so no frame
      @(negedge clk); bus.REQ = 2'b10;
      @(negedge clk); bus.REQ = '0;
      wait_ev(3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL drop_wait: got no ACK want ACK"); end
      if (ok) begin
         e = ev_q.pop_front();
         total++; if (e.ack !== 2'(1 << own) || e.resp !== frame_miso) begin bad++; $display("FAIL drop_ack: got ack=%b resp=%h want ack=%b resp=%h", e.ack, e.resp, 2'(1 << own), frame_miso); end
         exp_last = own; last_resp = frame_miso;
      end
      wait_busy(1'b0, 200, ok);
      repeat (100) @(negedge clk);
      total++; if (frames - f0 != 1 || ev_q.size() != 0 || bus.BUSY !== 1'b0) begin bad++; $display("FAIL drop_extra: got frames=%0d pulses=%0d busy=%b want 1 0 0", frames - f0, ev_q.size(), bus.BUSY); end
   endtask

   task automatic test_async_reset();
      bit ok; ev_t e; int f0; int own;
      fin_stuck = 1'b0; fin_delay = 136; hold_max = 0; ev_q.delete(); f0 = frames;
      bus.REQ_DATA = {16'h5A5A, 16'hC0DE};
      bus.REQ = 2'b01;
      wait_frame(f0 + 1, 100, ok);
      bus.REQ = '0;
      repeat (20) @(negedge clk);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      total++; if (bus.SPI_ENA !== 1'b0 || bus.BUSY !== 1'b0) begin bad++; $display("FAIL arst_immediate: got ena=%b busy=%b want 0 0", bus.SPI_ENA, bus.BUSY); end
      total++; if (bus.ACK !== '0 || bus.ERR !== '0 || bus.RESP_DATA !== 16'h0) begin bad++; $display("FAIL arst_outputs: got ack=%b err=%b resp=%h want 0 0 0000", bus.ACK, bus.ERR, bus.RESP_DATA); end
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      exp_last = NREQ - 1; last_resp = 16'h0; ev_q.delete();
      bus.REQ = 2'b11;
      own = rr_pick(exp_last, 2'b11);
      wait_busy(1'b1, 50, ok); bus.REQ = '0;
      wait_ev(3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL arst_wait: got no ACK want ACK"); end
      if (ok) begin
         e = ev_q.pop_front();
         total++; if (e.ack !== 2'(1 << own)) begin bad++; $display("FAIL arst_owner: got %b want %b", e.ack, 2'(1 << own)); end
         total++; if (t_ena_rise - t_grant != SETUP || mosi_rise !== 16'hC0DE) begin bad++; $display("FAIL arst_setup: got setup=%0d mosi=%h want %0d c0de", t_ena_rise - t_grant, mosi_rise, SETUP); end
         exp_last = own; last_resp = frame_miso;
      end
      wait_busy(1'b0, 200, ok);
   endtask

   initial begin
      bus.REQ = '0; bus.REQ_DATA = '0;
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_req_drop();
      test_async_reset();
      total++; if (viol != 0) begin bad++; $display("FAIL onehot_pulse: got %0d violations want 0", viol); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
